// File: rtl/llc_snoop_responder.sv
// LLC snoop responder: answers snooped bus ops with NOHIT/HIT/HITM from a
// direct-mapped MESI state/tag array, drives GETLINE/INVALIDATELINE to L1
// and a DRAM writeback on modified hits, then applies the MESI transition.
// Optional statistics counters are built when SNOOP_STATS_EN is defined.
module llc_snoop_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  snp_valid,
  output logic                  snp_ready,
  input  logic [2:0]            snp_op,
  input  logic [ADDR_WIDTH-1:0] snp_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_result,
  output logic                  l1_msg_valid,
  output logic [2:0]            l1_msg,
  output logic [ADDR_WIDTH-1:0] l1_msg_addr,
  input  logic                  l1_msg_ack,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic                  wb_ack,
  input  logic                  fill_valid,
  output logic                  fill_ready,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [1:0]            fill_state,
  output logic                  protocol_err,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           hitm_cnt,
  output logic [15:0]           nohit_cnt
);

  localparam int          TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned DEPTH    = 1 << INDEX_BITS;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_GETL, ST_WB, ST_INVL, ST_RESP
  } fsm_e;

  typedef enum logic [1:0] {
    MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [2:0] {
    OP_READ = 3'd1, OP_WRITE = 3'd2, OP_INVALIDATE = 3'd3, OP_RWIM = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    RES_NOHIT = 2'd0, RES_HIT = 2'd1, RES_HITM = 2'd2
  } res_e;

  fsm_e                  state, state_next;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  res_e                  result_q;
  mesi_e                 new_q;
  logic                  getl_q, wb_q, invl_q;
  logic                  err_q;

  logic [TAG_BITS-1:0]   tag_arr [DEPTH];
  mesi_e                 st_arr  [DEPTH];

  logic [INDEX_BITS-1:0] idx, fill_idx;
  logic [TAG_BITS-1:0]   tag, fill_tag;
  mesi_e                 entry_st, commit_st;
  logic                  hit, fill_fire, commit;

  res_e                  lk_result;
  mesi_e                 lk_new;
  logic                  lk_getl, lk_wb, lk_invl, lk_err;

  logic                  unused_fill_offset;

  assign idx      = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign tag      = addr_q[ADDR_WIDTH-1 -: TAG_BITS];
  assign fill_idx = fill_addr[OFFSET_BITS +: INDEX_BITS];
  assign fill_tag = fill_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign unused_fill_offset = ^fill_addr[OFFSET_BITS-1:0];

  assign entry_st  = st_arr[idx];
  assign hit       = (entry_st != MESI_I) && (tag_arr[idx] == tag);
  assign fill_fire = (state == ST_IDLE) && !snp_valid && fill_valid;

  // The array commits on the edge that enters RESP; from LOOKUP the new state
  // has not been registered yet, so it is taken straight from the lookup.
  assign commit    = (state != ST_RESP) && (state_next == ST_RESP);
  assign commit_st = (state == ST_LOOKUP) ? lk_new : new_q;

  // Lookup: result, next MESI state and required actions for the latched snoop
  always_comb begin
    lk_result = RES_NOHIT;
    lk_new    = entry_st;
    lk_getl   = 1'b0;
    lk_wb     = 1'b0;
    lk_invl   = 1'b0;
    lk_err    = 1'b0;
    case (op_q)
      OP_READ: if (hit) begin
        lk_new = MESI_S;
        if (entry_st == MESI_M) begin
          lk_result = RES_HITM;
          lk_getl   = 1'b1;
          lk_wb     = 1'b1;
        end else begin
          lk_result = RES_HIT;
        end
      end
      OP_RWIM: if (hit) begin
        lk_new  = MESI_I;
        lk_invl = 1'b1;
        if (entry_st == MESI_M) begin
          lk_result = RES_HITM;
          lk_getl   = 1'b1;
          lk_wb     = 1'b1;
        end else begin
          lk_result = RES_HIT;
        end
      end
      OP_INVALIDATE: if (hit) begin
        if (entry_st == MESI_S) begin
          lk_new    = MESI_I;
          lk_result = RES_HIT;
          lk_invl   = 1'b1;
        end else begin
          lk_err = 1'b1;
        end
      end
      OP_WRITE: if (hit) lk_err = 1'b1;
      default: lk_err = 1'b1;
    endcase
  end

  // Next-state logic: actions run in GETL -> WB -> INVL order, absent ones skipped
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (snp_valid) state_next = ST_LOOKUP;
      ST_LOOKUP: begin
        if (lk_getl)      state_next = ST_GETL;
        else if (lk_wb)   state_next = ST_WB;
        else if (lk_invl) state_next = ST_INVL;
        else              state_next = ST_RESP;
      end
      ST_GETL: if (l1_msg_ack) begin
        if (wb_q)        state_next = ST_WB;
        else if (invl_q) state_next = ST_INVL;
        else             state_next = ST_RESP;
      end
      ST_WB: if (wb_ack) state_next = invl_q ? ST_INVL : ST_RESP;
      ST_INVL: if (l1_msg_ack) state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register plus latched snoop and lookup results
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      result_q <= RES_NOHIT;
      new_q    <= MESI_I;
      getl_q   <= 1'b0;
      wb_q     <= 1'b0;
      invl_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      err_q <= (state == ST_LOOKUP) && lk_err;
      if (state == ST_IDLE && snp_valid) begin
        op_q                   <= snp_op;
        addr_q                 <= snp_addr;
        addr_q[OFFSET_BITS-1:0] <= '0;
      end
      if (state == ST_LOOKUP) begin
        result_q <= lk_result;
        new_q    <= lk_new;
        getl_q   <= lk_getl;
        wb_q     <= lk_wb;
        invl_q   <= lk_invl;
      end
    end
  end

  // MESI state/tag array: snoop commit or local fill (never both in one cycle)
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        st_arr[i]  <= MESI_I;
        tag_arr[i] <= '0;
      end
    end else if (commit) begin
      st_arr[idx] <= commit_st;
    end else if (fill_fire) begin
      st_arr[fill_idx]  <= mesi_e'(fill_state);
      tag_arr[fill_idx] <= fill_tag;
    end
  end

  // Output decode from FSM state and latched line address
  always_comb begin
    l1_msg = 3'd0;
    if (state == ST_GETL) l1_msg = 3'd1;
    if (state == ST_INVL) l1_msg = 3'd3;
  end

  assign snp_ready    = (state == ST_IDLE);
  assign fill_ready   = (state == ST_IDLE) && !snp_valid;
  assign rsp_valid    = (state == ST_RESP);
  assign rsp_result   = result_q;
  assign l1_msg_valid = (state == ST_GETL) || (state == ST_INVL);
  assign l1_msg_addr  = addr_q;
  assign wb_valid     = (state == ST_WB);
  assign wb_addr      = addr_q;
  assign protocol_err = err_q;

`ifdef SNOOP_STATS_EN
  logic [15:0] hit_q, hitm_q, nohit_q;

  // Saturating per-result counters, bumped on each response handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q   <= '0;
      hitm_q  <= '0;
      nohit_q <= '0;
    end else if (state == ST_RESP && rsp_ready) begin
      case (result_q)
        RES_HIT:   if (hit_q   != '1) hit_q   <= hit_q + 16'd1;
        RES_HITM:  if (hitm_q  != '1) hitm_q  <= hitm_q + 16'd1;
        default:   if (nohit_q != '1) nohit_q <= nohit_q + 16'd1;
      endcase
    end
  end

  assign hit_cnt   = hit_q;
  assign hitm_cnt  = hitm_q;
  assign nohit_cnt = nohit_q;
`else
  assign hit_cnt   = '0;
  assign hitm_cnt  = '0;
  assign nohit_cnt = '0;
`endif

endmodule

// File: tb/tb_llc_snoop_responder.sv
// Scoreboard bench for llc_snoop_responder: expected responses and L1/WB
// messages are queued when a snoop is driven and checked as the DUT emits them.
module tb_llc_snoop_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        snp_valid, snp_ready;
  logic [2:0]  snp_op;
  logic [31:0] snp_addr;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_result;
  logic        l1_msg_valid;
  logic [2:0]  l1_msg;
  logic [31:0] l1_msg_addr;
  logic        l1_msg_ack;
  logic        wb_valid;
  logic [31:0] wb_addr;
  logic        wb_ack;
  logic        fill_valid, fill_ready;
  logic [31:0] fill_addr;
  logic [1:0]  fill_state;
  logic        protocol_err;
  logic [15:0] hit_cnt, hitm_cnt, nohit_cnt;

  llc_snoop_responder #(.ADDR_WIDTH(32), .OFFSET_BITS(6), .INDEX_BITS(4)) dut (
    .clock(clock), .reset(reset),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .l1_msg_valid(l1_msg_valid), .l1_msg(l1_msg), .l1_msg_addr(l1_msg_addr),
    .l1_msg_ack(l1_msg_ack), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ack(wb_ack),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
    .fill_state(fill_state), .protocol_err(protocol_err),
    .hit_cnt(hit_cnt), .hitm_cnt(hitm_cnt), .nohit_cnt(nohit_cnt)
  );

  always #5 clock = ~clock;

  localparam logic [2:0] READ = 3'd1, WRITE = 3'd2, INVAL = 3'd3, RWIM = 3'd4;
  localparam logic [1:0] NOHIT = 2'd0, HIT = 2'd1, HITM = 2'd2;
  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
  // message kinds: 1 GETLINE, 3 INVALIDATELINE, 4 DRAM writeback
  localparam logic [2:0] K_GETL = 3'd1, K_INVL = 3'd3, K_WB = 3'd4;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] addr;
  } msg_t;

  msg_t       exp_msg[$];
  logic [1:0] exp_rsp[$];

  int checks   = 0;
  int failures = 0;
  int m_hit = 0, m_hitm = 0, m_nohit = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_cnt(input int model);
`ifdef SNOOP_STATS_EN
    return model;
`else
    return 0 * model;
`endif
  endfunction

  function automatic void push_msg(input logic [2:0] kind, input logic [31:0] addr);
    msg_t m;
    m.kind = kind;
    m.addr = addr;
    exp_msg.push_back(m);
  endfunction

  task automatic check_counters(input string tag);
    check_eq({tag, "_hit_cnt"},   32'(hit_cnt),   exp_cnt(m_hit));
    check_eq({tag, "_hitm_cnt"},  32'(hitm_cnt),  exp_cnt(m_hitm));
    check_eq({tag, "_nohit_cnt"}, 32'(nohit_cnt), exp_cnt(m_nohit));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_snp_ready"},  32'(snp_ready), 1);
    check_eq({tag, "_fill_ready"}, 32'(fill_ready), 1);
    check_eq({tag, "_rsp_valid"},  32'(rsp_valid), 0);
    check_eq({tag, "_rsp_result"}, 32'(rsp_result), 0);
    check_eq({tag, "_l1_valid"},   32'(l1_msg_valid), 0);
    check_eq({tag, "_wb_valid"},   32'(wb_valid), 0);
    check_eq({tag, "_perr"},       32'(protocol_err), 0);
    check_eq({tag, "_l1_addr"},    l1_msg_addr, 0);
    check_eq({tag, "_wb_addr"},    wb_addr, 0);
    check_counters(tag);
  endtask

  task automatic do_fill(input logic [31:0] addr, input logic [1:0] st);
    @(negedge clock);
    fill_valid = 1'b1;
    fill_addr  = addr;
    fill_state = st;
    check_eq("fill_ready", 32'(fill_ready), 1);
    @(posedge clock);
    #1 fill_valid = 1'b0;
  endtask

  // Drives one snoop, acks each action after ack_dly cycles, holds rsp_ready
  // low for rsp_hold cycles of RESP, and checks against the queued expectations.
  task automatic run_snoop(input logic [2:0] op, input logic [31:0] addr, input int ack_dly,
                           input int rsp_hold, input int exp_err, input int exp_lat);
    int         wait_ct, err_ct, hold;
    bit         busy, done, first;
    logic [1:0] res;
    msg_t       m;
    @(negedge clock);
    check_eq("idle_ready", 32'(snp_ready), 1);
    snp_valid = 1'b1;
    snp_op    = op;
    snp_addr  = addr;
    @(posedge clock);
    #1 snp_valid = 1'b0;
    busy = 0; done = 0; first = 1; err_ct = 0; hold = 0; wait_ct = 0; res = NOHIT;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clock);
      l1_msg_ack = 1'b0;
      wb_ack     = 1'b0;
      check_eq("busy_ready", 32'(snp_ready), 0);
      if (protocol_err) begin
        err_ct++;
        check_eq("err_cycle", c, 2);
      end
      if (l1_msg_valid || wb_valid) begin
        if (!busy) begin
          busy = 1;
          wait_ct = 0;
          if (exp_msg.size() == 0) begin
            check_eq("unexpected_msg", {30'd0, l1_msg_valid, wb_valid}, 0);
          end else begin
            m = exp_msg.pop_front();
            check_eq("msg_kind", wb_valid ? 32'(K_WB) : 32'(l1_msg), 32'(m.kind));
            check_eq("msg_addr", wb_valid ? wb_addr : l1_msg_addr, m.addr);
          end
        end
        if (wait_ct == ack_dly) begin
          if (wb_valid) wb_ack = 1'b1;
          else l1_msg_ack = 1'b1;
          busy = 0;
        end else begin
          wait_ct++;
        end
      end
      if (rsp_valid) begin
        if (first) begin
          first = 0;
          if (exp_lat != 0) check_eq("rsp_latency", c, exp_lat);
          if (exp_rsp.size() == 0) check_eq("unexpected_rsp", 1, 0);
          else res = exp_rsp.pop_front();
        end
        check_eq("rsp_result", 32'(rsp_result), 32'(res));
        if (hold >= rsp_hold) begin
          rsp_ready = 1'b1;
          done = 1;
          if (res == HIT) m_hit++;
          else if (res == HITM) m_hitm++;
          else m_nohit++;
        end else begin
          hold++;
        end
      end
    end
    if (!done) check_eq("rsp_timeout", 0, 1);
    @(posedge clock);
    #1;
    rsp_ready  = 1'b0;
    l1_msg_ack = 1'b0;
    wb_ack     = 1'b0;
    check_eq("msgs_left", exp_msg.size(), 0);
    exp_msg.delete();
    check_eq("err_pulses", err_ct, exp_err);
  endtask

  initial begin
    bit reached;
    reset = 1'b1;
    snp_valid = 1'b0; snp_op = '0; snp_addr = '0;
    rsp_ready = 1'b0; l1_msg_ack = 1'b0; wb_ack = 1'b0;
    fill_valid = 1'b0; fill_addr = '0; fill_state = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset");

    // cold miss, no traffic
    exp_rsp.push_back(NOHIT);
    run_snoop(READ, 32'h0000_1040, 0, 0, 0, 2);

    // E hit degrades to S; second READ still hits
    do_fill(32'h0000_1040, ST_E);
    exp_rsp.push_back(HIT);
    run_snoop(READ, 32'h0000_1040, 0, 0, 0, 2);
    exp_rsp.push_back(HIT);
    run_snoop(READ, 32'h0000_1040, 0, 0, 0, 2);

    // RWIM on M with slow acks: GETLINE, WB, INVALIDATELINE then HITM
    do_fill(32'h0000_2080, ST_M);
    push_msg(K_GETL, 32'h0000_2080);
    push_msg(K_WB,   32'h0000_2080);
    push_msg(K_INVL, 32'h0000_2080);
    exp_rsp.push_back(HITM);
    run_snoop(RWIM, 32'h0000_2080, 3, 0, 0, 14);
    exp_rsp.push_back(NOHIT);
    run_snoop(READ, 32'h0000_2080, 0, 0, 0, 2);

    // INVALIDATE of S, then WRITE hitting M flags an error and leaves M
    do_fill(32'h0000_3000, ST_S);
    push_msg(K_INVL, 32'h0000_3000);
    exp_rsp.push_back(HIT);
    run_snoop(INVAL, 32'h0000_3000, 0, 0, 0, 3);
    do_fill(32'h0000_3000, ST_M);
    exp_rsp.push_back(NOHIT);
    run_snoop(WRITE, 32'h0000_3000, 0, 0, 1, 2);
    push_msg(K_GETL, 32'h0000_3000);
    push_msg(K_WB,   32'h0000_3000);
    exp_rsp.push_back(HITM);
    run_snoop(READ, 32'h0000_3000, 0, 0, 0, 4);
    exp_rsp.push_back(NOHIT);
    run_snoop(3'd5, 32'h0000_3000, 0, 0, 1, 2);

    // same index, different tag; response held 5 cycles
    exp_rsp.push_back(NOHIT);
    run_snoop(READ, 32'h0001_1040, 0, 5, 0, 2);
    // unaligned RWIM on the S line: message carries the line address
    push_msg(K_INVL, 32'h0000_1040);
    exp_rsp.push_back(HIT);
    run_snoop(RWIM, 32'h0000_1047, 1, 0, 0, 4);
    check_counters("mid");

    // reset while waiting for the writeback ack
    do_fill(32'h0000_5000, ST_M);
    @(negedge clock);
    snp_valid = 1'b1; snp_op = READ; snp_addr = 32'h0000_5010;
    @(posedge clock);
    #1 snp_valid = 1'b0;
    reached = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      @(negedge clock);
      l1_msg_ack = l1_msg_valid && (l1_msg == 3'd1);
      if (wb_valid) reached = 1;
    end
    check_eq("wb_reached", 32'(reached), 1);
    check_eq("wb_addr_pre_reset", wb_addr, 32'h0000_5000);
    l1_msg_ack = 1'b0;
    reset  = 1'b1;
    wb_ack = 1'b1;
    m_hit = 0; m_hitm = 0; m_nohit = 0;
    @(posedge clock);
    #1;
    check_reset_outputs("midreset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("stray_ack_ignored", 32'(wb_valid), 0);
    wb_ack = 1'b0;
    exp_rsp.push_back(NOHIT);
    run_snoop(READ, 32'h0000_5000, 0, 0, 0, 2);
    @(negedge clock);
    check_counters("final");
    check_eq("rsp_left", exp_rsp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
